amstrad_io_replay: RTL
======================

# amstrad_io_replay

Snapshot I/O replay sequencer: the initiator side of the CPC I/O write bus that the MMU and Gate Array decode. On `start` it requests the Z80 bus and issues a fixed sequence of `OUT` cycles (pen/ink, mode/ROM config, RAM config, ROM select) built from bytes of a loaded SNA header. Restore paths and CRTC/MMU/GA receivers then see ordinary CPU writes. It sits beside the CPU in the motherboard and is muxed onto `A`/`D`/`io_WR` while `bus_oe` is high.

## Interface
- `WR_CYCLES`, 4, clocks `io_WR` is held high per write (≥1)
- `GAP_CYCLES`, 4, clocks of `io_WR` low after each write (≥1)
- `CLK  in  1  system clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `start  in  1  one-cycle request; ignored while busy`
- `busrq_n  out  1  Z80 bus request, active low`
- `busak_n  in  1  Z80 bus acknowledge, active low`
- `snap_addr  out  7  SNA header byte offset`
- `snap_rd  out  1  read strobe; snap_data valid the next cycle`
- `snap_data  in  8  header byte`
- `A  out  16  I/O address`
- `D  out  8  I/O write data`
- `io_WR  out  1  I/O write strobe, active high`
- `bus_oe  out  1  A/D/io_WR own the bus`
- `busy  out  1  sequence in progress`
- `done  out  1  one-cycle completion pulse`

## Operation
- Command index `idx` (7 bits) walks a fixed table; each entry = {snap offset, A[15:8], data form}.
- Base table, 38 entries:
  - idx 2k / 2k+1, k=0..16:
    - pen select: offset 0x2E, A=7F00, D={3'b000,k[4:0]}; fetched byte discarded.
    - ink: offset 0x2F+k, A=7F00, D={3'b010,byte[4:0]}.
  - idx 34: offset 0x40, A=7F00, D={2'b10,byte[5:0]}.
  - idx 35: offset 0x41, A[15:8]= byte[6] ? 7E : 7F, D={2'b11,byte[5:0]}.
  - idx 36: offset 0x2E, A=7F00, D={3'b000,byte[4:0]} (restore pen).
  - idx 37: offset 0x55, A=DF00, D=byte.
- A[7:0] always 0.
- FSM states and transitions:
  - IDLE: on `start` → REQ; `busy`=1.
  - REQ: `busrq_n`=0; when `busak_n` sampled low → FETCH.
  - FETCH: `snap_rd`=1, `snap_addr`=entry offset.
  - LATCH: capture `snap_data`.
  - SETUP: `bus_oe`=1, A/D driven.
  - STROBE: `io_WR`=1 for WR_CYCLES.
  - HOLD: `io_WR`=0, A/D held, GAP_CYCLES; then:
    - last idx → DONE
    - `busak_n` high → REQ (idx advanced)
    - else → FETCH with idx+1.
  - DONE: `done`=1, `busrq_n`=1 → IDLE.
- `busak_n` rising mid-write never truncates a strobe; the write completes, then the sequencer waits in REQ with no repeated or skipped entry.
- `start` while busy is ignored.

## Timing
- Reset (async, any state): `busrq_n`=1; `io_WR`, `bus_oe`, `snap_rd`, `busy`, `done`=0; A, `snap_addr`, D, idx=0.
- Start → `busrq_n` low: 1 cycle.
- Per write: 3+WR_CYCLES+GAP_CYCLES cycles (11 default). A/D stable ≥1 cycle before `io_WR` rise and through GAP after fall.
- Uninterrupted base sequence: 38×11 = 418 cycles from grant to DONE.
- `busy` is high from the cycle after `start` through DONE inclusive.

## Configuration
- `IO_REPLAY_CRTC_EN` defined:
  - after idx 37, 37 more entries:
    - for r=0..17: A=BC00 D=r (offset 0x42, discarded), then A=BD00 D=byte at 0x43+r.
    - finally A=BC00 D=byte at 0x42.
  - 75 writes total.
- Undefined: sequence ends at idx 37; no BCxx/BDxx cycles.

## Structure
- Shared package `amstrad_io_pkg`:
  - FSM state enum
  - port address constants 7F/7E/DF/BC/BD
  - SNA offset constants
  - table entry struct {offset, a_hi, form}
  - entry counts 38/75
- Sub-module `amstrad_io_replay_table`: combinational idx + fetched byte → {snap_addr, A, D, last}. Holds all `IO_REPLAY_CRTC_EN` conditionals.

## Test plan
- Inks 0x2F..0x3F = 0x20+k, grant immediate:
  - exactly 38 `io_WR` rising edges.
  - write0 A=7F00 D=00; write1 D=0x40; write33 D=0x50.
  - `done` pulses at cycle 418 after grant.
- [0x41]=0x45 → write 35 A=7E00 D=0xC5; [0x41]=0x05 → A=7F00 D=0xC5; [0x55]=0x07 → last write A=DF00 D=07.
- `busak_n` held high 20 cycles after start: `busrq_n` low throughout, no `io_WR`, `bus_oe`=0; first strobe 3 cycles after grant.
- `busak_n` rises during write 10 STROBE: `io_WR` stays high full WR_CYCLES; on regrant the next write is 11, strobe count still 38.
- `reset_n` low mid-STROBE: `io_WR`/`bus_oe`=0 and `busrq_n`=1 same cycle; after release, `start` replays from write 0.
- With `IO_REPLAY_CRTC_EN`, [0x42]=0x0C, [0x43+r]=r+0x30: 75 strobes; write 38 A=BC00 D=00; write 39 A=BD00 D=0x30; final write A=BC00 D=0x0C.

Source files
------------

// File: rtl/amstrad_io_pkg.sv
// amstrad_io_pkg: shared definitions for the snapshot I/O replay sequencer.
//   - FSM state encoding
//   - CPC I/O port high-byte constants (Gate Array, MMU, ROM select, CRTC)
//   - SNA header byte offsets used by the replay table
//   - table entry struct and sequence lengths (base / with CRTC replay)
// The optional CRTC replay is enabled by the IO_REPLAY_CRTC_EN macro.
package amstrad_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_FETCH, S_LATCH, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    localparam logic [7:0] PORT_GA       = 8'h7F;
    localparam logic [7:0] PORT_GA_UPPER = 8'h7E;  // RAM config with byte[6] set
    localparam logic [7:0] PORT_ROMSEL   = 8'hDF;
    localparam logic [7:0] PORT_CRTC_SEL = 8'hBC;
    localparam logic [7:0] PORT_CRTC_DAT = 8'hBD;

    localparam logic [6:0] SNA_PEN       = 7'h2E;
    localparam logic [6:0] SNA_INK0      = 7'h2F;
    localparam logic [6:0] SNA_ROMCFG    = 7'h40;
    localparam logic [6:0] SNA_RAMCFG    = 7'h41;
    localparam logic [6:0] SNA_CRTC_SEL  = 7'h42;
    localparam logic [6:0] SNA_CRTC_REG0 = 7'h43;
    localparam logic [6:0] SNA_ROMSEL    = 7'h55;

    localparam int NUM_BASE = 38;
    localparam int NUM_CRTC = 75;

    // How the write data is formed from the fetched header byte.
    typedef enum logic [2:0] {
        F_IMM,     // constant data, fetched byte discarded
        F_INK,     // {010, byte[4:0]}
        F_ROMCFG,  // {10, byte[5:0]}
        F_RAMCFG,  // {11, byte[5:0]}, port depends on byte[6]
        F_PEN,     // {000, byte[4:0]}
        F_RAW      // byte as-is
    } form_t;

    typedef struct packed {
        logic [6:0] offset;
        logic [7:0] a_hi;
        form_t      form;
        logic [7:0] imm;
    } entry_t;

endpackage

// File: rtl/amstrad_io_replay_table.sv
// amstrad_io_replay_table: combinational replay command table.
//   idx       in  7  command index
//   fetched   in  8  header byte fetched for this command
//   snap_addr out 7  SNA offset to fetch for idx
//   a         out 16 I/O address
//   d         out 8  I/O write data
//   last      out 1  idx is the final command
// IO_REPLAY_CRTC_EN appends the 37 CRTC register writes after the base 38.
module amstrad_io_replay_table
    import amstrad_io_pkg::*;
(
    input  logic [6:0]  idx,
    input  logic [7:0]  fetched,
    output logic [6:0]  snap_addr,
    output logic [15:0] a,
    output logic [7:0]  d,
    output logic        last
);

`ifdef IO_REPLAY_CRTC_EN
    localparam logic [6:0] LAST_IDX = 7'(NUM_CRTC - 1);
    logic [5:0] j;  // index within the CRTC block
    assign j = 6'(idx - 7'd38);
`else
    localparam logic [6:0] LAST_IDX = 7'(NUM_BASE - 1);
`endif

    entry_t ent;

    always_comb begin
        ent = '{offset: SNA_PEN, a_hi: PORT_GA, form: F_IMM, imm: 8'h00};
        if (idx < 7'd34) begin
            // even: select pen k, odd: write ink k
            if (!idx[0]) begin
                ent.imm = {3'b000, idx[5:1]};
            end else begin
                ent.offset = SNA_INK0 + {2'b00, idx[5:1]};
                ent.form   = F_INK;
            end
        end else if (idx == 7'd34) begin
            ent.offset = SNA_ROMCFG;
            ent.form   = F_ROMCFG;
        end else if (idx == 7'd35) begin
            ent.offset = SNA_RAMCFG;
            ent.form   = F_RAMCFG;
        end else if (idx == 7'd36) begin
            ent.form   = F_PEN;
`ifdef IO_REPLAY_CRTC_EN
        end else if (idx == 7'd37) begin
            ent.offset = SNA_ROMSEL;
            ent.a_hi   = PORT_ROMSEL;
            ent.form   = F_RAW;
        end else if (idx < 7'd74) begin
            if (!j[0]) begin
                ent.offset = SNA_CRTC_SEL;
                ent.a_hi   = PORT_CRTC_SEL;
                ent.imm    = {3'b000, j[5:1]};
            end else begin
                ent.offset = SNA_CRTC_REG0 + {2'b00, j[5:1]};
                ent.a_hi   = PORT_CRTC_DAT;
                ent.form   = F_RAW;
            end
        end else begin
            // leave the CRTC pointing at the register the snapshot had selected
            ent.offset = SNA_CRTC_SEL;
            ent.a_hi   = PORT_CRTC_SEL;
            ent.form   = F_RAW;
        end
`else
        end else begin
            ent.offset = SNA_ROMSEL;
            ent.a_hi   = PORT_ROMSEL;
            ent.form   = F_RAW;
        end
`endif
    end

    always_comb begin
        a = {ent.a_hi, 8'h00};
        case (ent.form)
            F_IMM:    d = ent.imm;
            F_INK:    d = {3'b010, fetched[4:0]};
            F_ROMCFG: d = {2'b10, fetched[5:0]};
            F_RAMCFG: begin
                d = {2'b11, fetched[5:0]};
                if (fetched[6]) a = {PORT_GA_UPPER, 8'h00};
            end
            F_PEN:    d = {3'b000, fetched[4:0]};
            default:  d = fetched;
        endcase
    end

    assign snap_addr = ent.offset;
    assign last      = (idx == LAST_IDX);

endmodule

// File: rtl/amstrad_io_replay.sv
// amstrad_io_replay: snapshot I/O replay sequencer. On start it requests the
// Z80 bus and replays Gate Array / MMU / ROM select (and optionally CRTC)
// OUT cycles built from SNA header bytes.
//   CLK, reset_n         clock, async active-low reset
//   start                one-cycle request, ignored while busy
//   busrq_n / busak_n    Z80 bus request / acknowledge
//   snap_addr/rd/data    SNA header read port (data one cycle after rd)
//   A, D, io_WR, bus_oe  I/O write bus, owned while bus_oe is high
//   busy, done           status / one-cycle completion pulse
// IO_REPLAY_CRTC_EN (see table) extends the sequence with CRTC writes.
module amstrad_io_replay
    import amstrad_io_pkg::*;
#(
    parameter int WR_CYCLES  = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        start,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic [6:0]  snap_addr,
    output logic        snap_rd,
    input  logic [7:0]  snap_data,
    output logic [15:0] A,
    output logic [7:0]  D,
    output logic        io_WR,
    output logic        bus_oe,
    output logic        busy,
    output logic        done
);

    state_t      state;
    logic [6:0]  idx, idx_nxt;
    logic [7:0]  cnt;
    logic        last_q;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_a;
    logic [7:0]  tbl_d;
    logic        tbl_last;

    // The table looks at the index about to be used, so snap_addr can be
    // registered on the same edge that enters FETCH.
    always_comb begin
        idx_nxt = idx;
        if (state == S_HOLD && cnt == 8'd0 && !last_q) idx_nxt = idx + 7'd1;
    end

    amstrad_io_replay_table u_table (
        .idx       (idx_nxt),
        .fetched   (snap_data),
        .snap_addr (tbl_addr),
        .a         (tbl_a),
        .d         (tbl_d),
        .last      (tbl_last)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
            busrq_n   <= 1'b1;
            snap_addr <= '0;
            snap_rd   <= 1'b0;
            A         <= '0;
            D         <= '0;
            io_WR     <= 1'b0;
            bus_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        busy    <= 1'b1;
                        busrq_n <= 1'b0;
                        idx     <= '0;
                    end
                end
                S_REQ: begin
                    if (!busak_n) begin
                        state     <= S_FETCH;
                        snap_rd   <= 1'b1;
                        snap_addr <= tbl_addr;
                    end
                end
                S_FETCH: begin
                    snap_rd <= 1'b0;
                    state   <= S_LATCH;
                end
                S_LATCH: begin
                    // snap_data is valid now; A/D get a full SETUP cycle
                    A      <= tbl_a;
                    D      <= tbl_d;
                    last_q <= tbl_last;
                    bus_oe <= 1'b1;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    io_WR <= 1'b1;
                    cnt   <= 8'(WR_CYCLES - 1);
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    // busak_n is deliberately not looked at here
                    if (cnt == 8'd0) begin
                        io_WR <= 1'b0;
                        cnt   <= 8'(GAP_CYCLES - 1);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        bus_oe <= 1'b0;
                        if (last_q) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            busrq_n <= 1'b1;
                        end else begin
                            idx <= idx_nxt;
                            if (busak_n) begin
                                // bus taken back: resume at the next entry on regrant
                                state <= S_REQ;
                            end else begin
                                state     <= S_FETCH;
                                snap_rd   <= 1'b1;
                                snap_addr <= tbl_addr;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
